// File: rtl/tdc_multi_result_collector.sv
// Multi-channel TDC result collector: per-channel holding slots,
// round-robin merge into a shared FWFT FIFO, per-channel statistics.
module tdc_multi_result_collector #(
    parameter int NUM_CH     = 4,
    parameter int RESULT_W   = 32,
    parameter int CODE_W     = 8,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int COUNT_W    = 32,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic                                  enable,
    input  logic                                  clear_stats,
    input  logic                                  flush,
    input  logic [NUM_CH-1:0]                     ch_valid,
    input  logic [NUM_CH*RESULT_W-1:0]            ch_interval,
    input  logic [NUM_CH*CODE_W-1:0]              ch_code,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [CH_W+TS_W+CODE_W+RESULT_W-1:0]  out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level,
    output logic                                  drop_sticky,
    input  logic [CH_W-1:0]                       rd_ch,
    output logic [COUNT_W-1:0]                    rd_accept_cnt,
    output logic [COUNT_W-1:0]                    rd_drop_cnt,
    output logic [CODE_W+RESULT_W-1:0]            rd_last
);
    localparam int SW   = TS_W + CODE_W + RESULT_W;
    localparam int DW   = CH_W + SW;
    localparam int LW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LR_W = CODE_W + RESULT_W;

    logic [TS_W-1:0]    ts_q, ts_d;
    logic [NUM_CH-1:0]  slot_vld_q, slot_vld_d;
    logic [SW-1:0]      slot_q [NUM_CH];
    logic [SW-1:0]      slot_d [NUM_CH];
    logic [CH_W-1:0]    rr_q, rr_d;
    logic [DW-1:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wp_q, wp_d;
    logic [PW-1:0]      rp_q, rp_d;
    logic [LW-1:0]      lvl_q, lvl_d;
    logic [COUNT_W-1:0] acc_q [NUM_CH];
    logic [COUNT_W-1:0] acc_d [NUM_CH];
    logic [COUNT_W-1:0] drp_q [NUM_CH];
    logic [COUNT_W-1:0] drp_d [NUM_CH];
    logic [LR_W-1:0]    last_q [NUM_CH];
    logic [LR_W-1:0]    last_d [NUM_CH];
    logic               sticky_q, sticky_d;

    logic               gnt_vld;
    logic [CH_W-1:0]    gnt_idx;
    int                 scan;
    logic               push, pop, wr_en;

    // Round-robin pick of the first occupied slot from rr_q; none when full.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = 0;
        if (lvl_q != LW'(FIFO_DEPTH)) begin
            for (int k = 0; k < NUM_CH; k++) begin
                scan = (int'(rr_q) + k) % NUM_CH;
                if (!gnt_vld && slot_vld_q[scan]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = CH_W'(scan);
                end
            end
        end
    end

    assign push  = gnt_vld;
    assign pop   = out_valid & out_ready;
    assign wr_en = push & ~flush;

    // Next state: slot accept/drop, FIFO pointers, counters, flush/clear.
    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        slot_vld_d = slot_vld_q;
        slot_d     = slot_q;
        rr_d       = rr_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        acc_d      = acc_q;
        drp_d      = drp_q;
        last_d     = last_q;
        sticky_d   = sticky_q;
        if (push) begin
            slot_vld_d[gnt_idx] = 1'b0;
            rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
            wp_d = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
        lvl_d = lvl_q + LW'(push) - LW'(pop);
        for (int i = 0; i < NUM_CH; i++) begin
            if (enable && ch_valid[i]) begin
                // A slot granted this cycle is free again, so it can reload.
                if (!slot_vld_q[i] || (push && gnt_idx == CH_W'(i))) begin
                    slot_vld_d[i] = 1'b1;
                    slot_d[i] = {ts_q,
                                 ch_code[i*CODE_W +: CODE_W],
                                 ch_interval[i*RESULT_W +: RESULT_W]};
                    last_d[i] = {ch_code[i*CODE_W +: CODE_W],
                                 ch_interval[i*RESULT_W +: RESULT_W]};
                    if (acc_q[i] != '1) begin
                        acc_d[i] = acc_q[i] + COUNT_W'(1);
                    end
                end else begin
                    if (drp_q[i] != '1) begin
                        drp_d[i] = drp_q[i] + COUNT_W'(1);
                    end
                    sticky_d = 1'b1;
                end
            end
        end
        if (flush) begin
            slot_vld_d = '0;
            rr_d       = '0;
            wp_d       = '0;
            rp_d       = '0;
            lvl_d      = '0;
            acc_d      = acc_q;
            drp_d      = drp_q;
            last_d     = last_q;
            sticky_d   = sticky_q;
        end
        if (clear_stats) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
                drp_d[i] = '0;
            end
            sticky_d = 1'b0;
        end
    end

    // State registers, FIFO storage included so reset leaves no stale word.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_q       <= '0;
            slot_vld_q <= '0;
            rr_q       <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            lvl_q      <= '0;
            sticky_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_q[i] <= '0;
                acc_q[i]  <= '0;
                drp_q[i]  <= '0;
                last_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            slot_vld_q <= slot_vld_d;
            rr_q       <= rr_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            lvl_q      <= lvl_d;
            sticky_q   <= sticky_d;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_q[i] <= slot_d[i];
                acc_q[i]  <= acc_d[i];
                drp_q[i]  <= drp_d[i];
                last_q[i] <= last_d[i];
            end
            if (wr_en) begin
                mem_q[wp_q] <= {gnt_idx, slot_q[gnt_idx]};
            end
        end
    end

    assign out_valid   = (lvl_q != '0);
    assign out_data    = out_valid ? mem_q[rp_q] : '0;
    assign fifo_level  = lvl_q;
    assign drop_sticky = sticky_q;

    // Statistics readback; out-of-range selects read as zero.
    always_comb begin
        rd_accept_cnt = '0;
        rd_drop_cnt   = '0;
        rd_last       = '0;
        if (int'(rd_ch) < NUM_CH) begin
            rd_accept_cnt = acc_q[rd_ch];
            rd_drop_cnt   = drp_q[rd_ch];
            rd_last       = last_q[rd_ch];
        end
    end

endmodule

// File: doc/tdc_multi_result_collector.md
Name: tdc_multi_result_collector

Overview:
Parametrised N-channel result collector that sits between multiple TDC channel cores and the debug/readout path (ILA, VIO or future host interface). Each channel's measurement pulse is latched into a per-channel holding slot and tagged with a channel ID and a free-running timestamp. Tagged words are merged into a shared FWFT FIFO by round-robin arbitration. The block also keeps per-channel accepted/dropped counters and a last-result register readable via a select port.

Parameters:
NUM_CH, 4, number of TDC channels (1..16)
RESULT_W, 32, width of per-channel time_interval
CODE_W, 8, width of per-channel delay-line tap code
TS_W, 16, width of free-running timestamp counter
FIFO_DEPTH, 8, shared FIFO entries (power of 2, >=2)
COUNT_W, 32, width of per-channel saturating counters
CH_W, derived = max(1, clog2(NUM_CH)), channel ID width

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
enable  in  1  accept new channel results when high
clear_stats  in  1  synchronous clear of counters and sticky flag
flush  in  1  synchronous FIFO and slot flush
ch_valid  in  NUM_CH  per-channel one-cycle result strobe
ch_interval  in  NUM_CH*RESULT_W  per-channel interval; ch i at [i*RESULT_W +: RESULT_W]
ch_code  in  NUM_CH*CODE_W  per-channel tap code, same packing
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer ready
out_data  out  CH_W+TS_W+CODE_W+RESULT_W  {ch_id, timestamp, code, interval}
fifo_level  out  clog2(FIFO_DEPTH+1)  current occupancy
drop_sticky  out  1  set on any dropped result
rd_ch  in  CH_W  stats select
rd_accept_cnt  out  COUNT_W  accepted count for rd_ch
rd_drop_cnt  out  COUNT_W  dropped count for rd_ch
rd_last  out  CODE_W+RESULT_W  {code, interval} of last accepted result for rd_ch

Behaviour:
- Reset: all slots empty, FIFO empty, out_valid=0, out_data=0, fifo_level=0, drop_sticky=0, all counters/last registers 0, ts counter 0, rr_ptr=0.
- Timestamp: ts increments every cycle and wraps 2^TS_W-1 -> 0; it is not paused by enable.
- Slot accept: on an edge with enable=1 and ch_valid[i]=1, if slot i is empty or is granted in the same cycle, the slot loads {ts, code, interval}, accept_cnt[i] increments and last[i] updates. Otherwise the slot keeps its old content, drop_cnt[i] increments and drop_sticky is set.
- enable=0: ch_valid is ignored and not counted. Occupied slots continue draining.
- Counters saturate at 2^COUNT_W-1.
- Arbiter: each cycle with fifo_level<FIFO_DEPTH, grant the first occupied slot scanning from rr_ptr upward with wrap. The granted slot is written to the FIFO with ch_id=index, the slot is freed, and rr_ptr <= (grant+1) mod NUM_CH. At most one grant per cycle. When the FIFO is full, no grant is made and rr_ptr holds.
- Full is judged from occupancy at cycle start. Pop and grant in the same cycle are both performed and the level is unchanged.
- Latency: ch_valid sampled at edge t gives FIFO write at edge t+1 and out_valid=1 after edge t+1, when uncontended and the FIFO is empty.
- FIFO: first-word-fall-through. out_data is valid while out_valid=1 and is held stable until popped. Pop occurs on out_valid & out_ready. out_ready while empty has no effect.
- rd_* outputs are combinational muxes from registers selected by rd_ch. rd_ch >= NUM_CH returns 0.
- clear_stats: zeroes accept/drop counters and drop_sticky next edge; last[] and FIFO are untouched. An event coinciding with clear_stats is lost from the counts (clear wins).
- flush: empties FIFO and all slots, fifo_level=0 next edge, rr_ptr=0. Accepts, grants and pops in that cycle are discarded; a coinciding ch_valid is neither accepted nor counted.
- Async reset mid-operation: immediate return to the reset state, with no partial FIFO write.

Test Plan:
- NUM_CH=4: single ch_valid[2] with interval=0x1234, code=0x55 at ts=10 -> out_valid two edges later, out_data={2,10,0x55,0x1234}; rd_ch=2 shows accept=1, last={0x55,0x1234}.
- All four ch_valid in one cycle, out_ready=1 -> FIFO order ch0,ch1,ch2,ch3 on consecutive cycles; repeat the event -> order restarts at rr_ptr (ch0 after ch3).
- out_ready=0, 12 single-channel strobes on ch1 spaced 2 cycles apart -> fifo_level reaches 8, slot1 holds the 9th, the next 3 are dropped; drop_cnt[1]=3, drop_sticky=1; releasing out_ready drains 9 words.
- ch_valid[0] on consecutive cycles while the FIFO has space -> no drops, since the slot reloads on the grant cycle; accept_cnt[0] equals the strobe count.
- enable=0 during 5 strobes -> no FIFO writes and counts unchanged; clear_stats after drops -> counters and drop_sticky are 0 while the FIFO contents are preserved.
- flush with 5 entries and 2 occupied slots -> out_valid=0 and fifo_level=0 next cycle; sys_rst_n pulsed mid-burst -> all outputs return to reset values immediately.
